// File: rtl/pkt_hdr_buffer.sv
// Purpose: gathers an ingress byte stream into a zero-padded header window and hands it to the parser.
// Latency: start_o rises the cycle after the last byte; done_o pulses the cycle after parser_ready_i in WAIT.
// Backpressure: in_ready_o is low from LAUNCH through CLEAR; bytes past the window are drained at full rate.
module pkt_hdr_buffer #(
  parameter int HDR_MAX_LEN = 64,
  parameter int LEN_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  input  logic [7:0]                 in_data_i,
  input  logic                       in_last_i,
  output logic                       in_ready_o,
  output logic [8*HDR_MAX_LEN-1:0]   pkt_hdr_o,
  output logic [LEN_W-1:0]           pkt_len_o,
  output logic                       ovf_o,
  output logic                       start_o,
  input  logic                       parser_ready_i,
  output logic                       done_o
);

  // Pointer must be able to hold HDR_MAX_LEN itself, which marks "window full".
  localparam int PTR_W = $clog2(HDR_MAX_LEN + 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [8*HDR_MAX_LEN-1:0]  pkt_hdr_q;
  logic [LEN_W-1:0]          pkt_len_q;
  logic                      ovf_q;
  logic                      xfer;

  assign xfer = in_valid_i & in_ready_o;

  // State register; reset discards any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: LAUNCH ignores parser_ready_i because the parser's ready is stale until it sees start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (xfer && in_last_i) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (parser_ready_i) state_d = CLEAR;
      CLEAR:   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    in_ready_o = 1'b0;
    start_o    = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      FILL:    in_ready_o = 1'b1;
      LAUNCH:  start_o    = 1'b1;
      WAIT:    start_o    = 1'b1;
      CLEAR:   done_o     = 1'b1;
      default: in_ready_o = 1'b0;
    endcase
  end

  // Window fill / freeze / clear; bytes beyond the window only bump the length and set ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      pkt_hdr_q <= '0;
      pkt_len_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (xfer) begin
            if (wr_ptr_q < PTR_W'(HDR_MAX_LEN)) begin
              for (int i = 0; i < HDR_MAX_LEN; i++) begin
                if (wr_ptr_q == PTR_W'(i)) begin
                  pkt_hdr_q[8*i +: 8] <= in_data_i;
                end
              end
              wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end else begin
              ovf_q <= 1'b1;
            end
            if (pkt_len_q != {LEN_W{1'b1}}) begin
              pkt_len_q <= pkt_len_q + LEN_W'(1);
            end
          end
        end
        CLEAR: begin
          wr_ptr_q  <= '0;
          pkt_hdr_q <= '0;
          pkt_len_q <= '0;
          ovf_q     <= 1'b0;
        end
        default: begin
          wr_ptr_q <= wr_ptr_q;
        end
      endcase
    end
  end

  assign pkt_hdr_o = pkt_hdr_q;
  assign pkt_len_o = pkt_len_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pkt_hdr_buffer.sv
// Purpose: scoreboard bench for pkt_hdr_buffer; expected windows queued at stimulus, compared on done_o.
// Latency: inputs driven and outputs sampled on the falling edge, away from the active edge.
// Backpressure: byte driver holds each byte until in_ready_o was high at a rising edge (bounded).
module tb_pkt_hdr_buffer;

  localparam int HDR = 64;
  localparam int LW  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid_i;
  logic [7:0]       in_data_i;
  logic             in_last_i;
  logic             in_ready_o;
  logic [8*HDR-1:0] pkt_hdr_o;
  logic [LW-1:0]    pkt_len_o;
  logic             ovf_o;
  logic             start_o;
  logic             parser_ready_i;
  logic             done_o;

  typedef struct {
    logic [8*HDR-1:0] hdr;
    logic [LW-1:0]    len;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   pushed   = 0;
  int   done_cnt = 0;
  bit   auto_rdy = 1'b0;

  pkt_hdr_buffer #(.HDR_MAX_LEN(HDR), .LEN_W(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .in_last_i      (in_last_i),
    .in_ready_o     (in_ready_o),
    .pkt_hdr_o      (pkt_hdr_o),
    .pkt_len_o      (pkt_len_o),
    .ovf_o          (ovf_o),
    .start_o        (start_o),
    .parser_ready_i (parser_ready_i),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8*HDR-1:0] obs, input logic [8*HDR-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte from a falling edge; return how many rising edges it waited for in_ready_o.
  task automatic put(input logic [7:0] d, input logic last, output int stalls);
    logic ok;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    stalls     = 0;
    forever begin
      ok = in_ready_o;
      @(posedge clk);
      @(negedge clk);
      if (ok) break;
      stalls++;
      if (stalls > 50) begin
        check("put_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Send bytes base, base+1, ... and queue the window the parser should receive.
  task automatic send_pkt(input logic [7:0] base, input int n, input bit gaps, input bit hold,
                          output int st_first, output int st_rest);
    exp_t e;
    int   st;
    e.hdr = '0;
    for (int i = 0; i < n && i < HDR; i++) e.hdr[8*i +: 8] = 8'(int'(base) + i);
    e.len = LW'(n);
    e.ovf = (n > HDR);
    exp_q.push_back(e);
    pushed++;
    st_first = 0;
    st_rest  = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) idle(1);
      put(8'(int'(base) + i), (i == n - 1), st);
      if (i == 0) st_first = st; else st_rest += st;
      if (i != n - 1) check("start_early", start_o, 0);
    end
    if (!hold) begin
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
    end
  endtask

  // Parser stand-in: answers ready whenever it sees start.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_rdy) parser_ready_i = start_o;
    end
  end

  // Scoreboard consumer: every done pulse must match the oldest queued packet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_o) begin
        done_cnt++;
        check("done_start_low", start_o, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", done_o, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_hdr", pkt_hdr_o, e.hdr);
          check("sb_len", pkt_len_o, e.len);
          check("sb_ovf", ovf_o, e.ovf);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    int sf, sr, st, n;
    rst            = 1'b1;
    in_valid_i     = 1'b0;
    in_data_i      = 8'h00;
    in_last_i      = 1'b0;
    parser_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready_o, 1);
    check("rst_start", start_o, 0);
    check("rst_done",  done_o, 0);
    check("rst_len",   pkt_len_o, 0);
    check("rst_ovf",   ovf_o, 0);
    check("rst_hdr",   pkt_hdr_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // 14-byte packet; now in LAUNCH
    send_pkt(8'h00, 14, 1'b0, 1'b0, sf, sr);
    check("t1_start_rise", start_o, 1);
    check("t1_ready_low",  in_ready_o, 0);
    check("t1_len",        pkt_len_o, 14);
    check("t1_ovf",        ovf_o, 0);
    check("t1_hdr13",      pkt_hdr_o[8*13 +: 8], 8'h0D);
    check("t1_hdr14_up",   pkt_hdr_o[8*HDR-1:8*14], 0);

    // ready during LAUNCH ignored; ready three cycles later completes handoff
    parser_ready_i = 1'b1;
    @(negedge clk);
    parser_ready_i = 1'b0;
    check("t2_start_held", start_o, 1);
    check("t2_no_done",    done_o, 0);
    @(negedge clk);
    @(negedge clk);
    check("t2_still_wait", start_o, 1);
    parser_ready_i = 1'b1;
    @(negedge clk);
    parser_ready_i = 1'b0;
    check("t2_start_fall", start_o, 0);
    check("t2_done",       done_o, 1);
    check("t2_len_held",   pkt_len_o, 14);
    @(negedge clk);
    check("t2_done_pulse", done_o, 0);
    check("t2_hdr_clr",    pkt_hdr_o, 0);
    check("t2_len_clr",    pkt_len_o, 0);
    check("t2_ovf_clr",    ovf_o, 0);
    check("t2_ready",      in_ready_o, 1);

    auto_rdy = 1'b1;

    // 70-byte packet: no stall, window truncated
    send_pkt(8'h00, 70, 1'b0, 1'b0, sf, sr);
    check("t3_stall_first", sf, 0);
    check("t3_stall_rest",  sr, 0);
    check("t3_hdr63",       pkt_hdr_o[8*63 +: 8], 8'h3F);
    check("t3_len",         pkt_len_o, 70);
    check("t3_ovf",         ovf_o, 1);

    // back-to-back with in_valid_i held high
    idle(6);
    send_pkt(8'hA0, 5, 1'b0, 1'b1, sf, sr);
    send_pkt(8'hB0, 3, 1'b0, 1'b0, sf, sr);
    check("t4_stall_b2b", sf, 3);
    check("t4_stall_rest", sr, 0);

    // reset in the middle of a 10-byte packet
    idle(6);
    for (int i = 0; i < 5; i++) put(8'(8'h50 + i), 1'b0, st);
    in_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready", in_ready_o, 1);
    check("t5_start", start_o, 0);
    check("t5_done",  done_o, 0);
    check("t5_len",   pkt_len_o, 0);
    check("t5_ovf",   ovf_o, 0);
    check("t5_hdr",   pkt_hdr_o, 0);
    send_pkt(8'h60, 2, 1'b0, 1'b0, sf, sr);
    check("t5_len2", pkt_len_o, 2);

    // gapped valid over a 4-byte packet
    idle(6);
    send_pkt(8'hC0, 4, 1'b1, 1'b0, sf, sr);
    check("t6_len", pkt_len_o, 4);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", exp_q.size(), 0);
    check("done_count", done_cnt, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
